freq_div_bank: RTL and testbench

- Multi-channel programmable clock-divider bank.
- Each channel produces a 50% duty square wave. Its half-period is set at reset from a parameter and can be reprogrammed at runtime through a simple write port.
- Per-channel enable.
- Sits at top level beside the FSM, 7-seg, debouncer, LCD and beeper logic, and supplies all of their slow clocks and tones from the single board clock.

---
 rtl/freq_div_pkg.sv | 30 +++
 rtl/freq_div_ch.sv | 58 +++++
 rtl/freq_div_bank.sv | 51 +++++
 tb/tb_freq_div_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants for the clock-divider bank: channel count, counter width,
// channel role indices and the default half-period divisors.
package freq_div_pkg;

    localparam int NUM_CH_DEF = 7;
    localparam int CNT_W_DEF  = 26;

    localparam int CH_FSM     = 0;
    localparam int CH_7SEG    = 1;
    localparam int CH_DEB     = 2;
    localparam int CH_LCD     = 3;
    localparam int CH_BEEP500 = 4;
    localparam int CH_BEEP1K  = 5;
    localparam int CH_BEEP2K  = 6;

    localparam logic [CNT_W_DEF-1:0] DIV_FSM     = 26'd20_000_000;
    localparam logic [CNT_W_DEF-1:0] DIV_7SEG    = 26'd80_000;
    localparam logic [CNT_W_DEF-1:0] DIV_DEB     = 26'd400_000;
    localparam logic [CNT_W_DEF-1:0] DIV_LCD     = 26'd20_000;
    localparam logic [CNT_W_DEF-1:0] DIV_BEEP500 = 26'd40_000;
    localparam logic [CNT_W_DEF-1:0] DIV_BEEP1K  = 26'd20_000;
    localparam logic [CNT_W_DEF-1:0] DIV_BEEP2K  = 26'd10_000;

    // Channel 0 sits in the least significant slice.
    localparam logic [NUM_CH_DEF*CNT_W_DEF-1:0] DIV_INIT_DEF = {
        DIV_BEEP2K, DIV_BEEP1K, DIV_BEEP500, DIV_LCD,
        DIV_DEB, DIV_7SEG, DIV_FSM
    };

endpackage

// File: rtl/freq_div_ch.sv
// One divider channel: half-period counter, divisor register, output toggle
// flop and (with FREQ_DIV_TICK_EN defined) a one-cycle tick per toggle.
import freq_div_pkg::*;

module freq_div_ch #(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_INIT = '1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] wr_div,
`ifdef FREQ_DIV_TICK_EN
    output logic             tick,
`endif
    output logic             clk_out
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_reg;
    logic             running;
    logic             term;

    // A zero divisor or a dropped enable parks the channel.
    assign running = en && (div_reg != '0);
    // A write wins over the terminal count, so the level never flips on a load.
    assign term    = running && (cnt == div_reg) && !load;

    // Counter, divisor and output level; a load clears the count but keeps the level.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt     <= '0;
            div_reg <= DIV_INIT;
            clk_out <= 1'b0;
        end else if (load) begin
            div_reg <= wr_div;
            cnt     <= '0;
        end else if (!running) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (term) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

`ifdef FREQ_DIV_TICK_EN
    // Tick is registered alongside clk_out so both change on the same edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) tick <= 1'b0;
        else        tick <= term;
    end
`endif

endmodule

// File: rtl/freq_div_bank.sv
// Multi-channel programmable clock-divider bank. Each channel emits a 50% duty
// square wave with half-period div+1 cycles of Clk. Optional per-channel tick
// strobes are present when FREQ_DIV_TICK_EN is defined.
import freq_div_pkg::*;

module freq_div_bank #(
    parameter int                        NUM_CH   = NUM_CH_DEF,
    parameter int                        CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = DIV_INIT_DEF,
    localparam int                       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
`ifdef FREQ_DIV_TICK_EN
    output logic [NUM_CH-1:0] tick,
`endif
    output logic [NUM_CH-1:0] clk_out
);

    logic [NUM_CH-1:0] load;

    // Decode the write index; out-of-range indices match no channel.
    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = wr_en && (wr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        freq_div_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_ch (
            .Clk     (Clk),
            .Rst_n   (Rst_n),
            .en      (ch_en[g]),
            .load    (load[g]),
            .wr_div  (wr_div),
`ifdef FREQ_DIV_TICK_EN
            .tick    (tick[g]),
`endif
            .clk_out (clk_out[g])
        );
    end

endmodule

// File: tb/tb_freq_div_bank.sv
// Randomized scoreboard bench for freq_div_bank. The reference model tracks, per
// channel, the number of counting cycles since the last restart point and the
// output level at that point; the output is derived arithmetically from those.
module tb_freq_div_bank;

    localparam int NUM_CH = 7;
    localparam int CNT_W  = 26;
    localparam int INIT   = 3;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic [NUM_CH-1:0] ch_en;
    logic              wr_en;
    logic [2:0]        wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick_dut;

    int vectors = 0;
    int miscompares = 0;

    freq_div_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DIV_INIT ({7{26'd3}})
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .ch_en   (ch_en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
`ifdef FREQ_DIV_TICK_EN
        .tick    (tick_dut),
`endif
        .clk_out (clk_out)
    );

`ifndef FREQ_DIV_TICK_EN
    assign tick_dut = '0;
`endif

    always #5 Clk = ~Clk;

    // Reference model state.
    longint p      [NUM_CH];
    logic   anchor [NUM_CH];
    longint div    [NUM_CH];
    logic   lvl    [NUM_CH];
    logic   tk     [NUM_CH];

    logic [2*NUM_CH-1:0] exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            p[i] = 0; anchor[i] = 1'b0; div[i] = INIT; lvl[i] = 1'b0; tk[i] = 1'b0;
        end
    endfunction

    // Advance the model by one Clk rising edge using the current inputs.
    function automatic void model_step();
        logic [2*NUM_CH-1:0] e;
        if (!Rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en && int'(wr_ch) == i) begin
                    anchor[i] = lvl[i];
                    p[i] = 0;
                    div[i] = longint'(wr_div);
                end else if (!ch_en[i] || div[i] == 0) begin
                    anchor[i] = 1'b0;
                    p[i] = 0;
                end else begin
                    p[i] = p[i] + 1;
                end
                lvl[i] = anchor[i] ^ (((p[i] / (div[i] + 1)) % 2) == 1);
                tk[i]  = (p[i] > 0) && (p[i] % (div[i] + 1) == 0);
            end
        end
        e = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            e[i] = lvl[i];
`ifdef FREQ_DIV_TICK_EN
            e[NUM_CH+i] = tk[i];
`endif
        end
        exp_q.push_back(e);
    endfunction

    // Monitor: every cycle the DUT presents outputs; compare against the queue.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            logic [2*NUM_CH-1:0] e;
            logic [2*NUM_CH-1:0] a;
            e = exp_q.pop_front();
            a = {tick_dut, clk_out};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t actual tick=%b clk_out=%b required tick=%b clk_out=%b",
                         $time, a[2*NUM_CH-1:NUM_CH], a[NUM_CH-1:0],
                         e[2*NUM_CH-1:NUM_CH], e[NUM_CH-1:0]);
            end
        end
    end

    // Returns at negedge+1 after n rising edges, ready for new inputs.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge Clk);
            model_step();
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic write(input int ch, input int d);
        wr_en = 1'b1; wr_ch = 3'(ch); wr_div = CNT_W'(d);
        run(1);
        wr_en = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0; ch_en = '1; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        model_reset();
        run(3);
        Rst_n = 1'b1;
        run(20);

        write(2, 1);
        run(12);

        begin
            int k;
            for (k = 0; k < 20 && (p[0] % (div[0] + 1)) != div[0]; k++) run(1);
            vectors++;
            if ((p[0] % (div[0] + 1)) != div[0]) begin
                miscompares++;
                $display("FAIL ch0_terminal_wait actual phase=%0d required phase=%0d", p[0], div[0]);
            end
        end
        write(0, 5);
        run(16);

        write(4, 0);
        run(6);
        write(4, 2);
        run(10);

        ch_en[1] = 1'b0;
        run(10);
        ch_en[1] = 1'b1;
        run(10);

        write(7, 9);
        run(10);

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(31) == 0) ch_en[i] = ~ch_en[i];
            if ($urandom_range(7) == 0) begin
                wr_en = 1'b1; wr_ch = 3'($urandom_range(7)); wr_div = CNT_W'($urandom_range(7));
            end else begin
                wr_en = 1'b0;
            end
            run(1);
        end
        wr_en = 1'b0;
        run(5);

        #1;
        Rst_n = 1'b0;
        #1;
        vectors++;
        if (clk_out !== '0 || tick_dut !== '0) begin
            miscompares++;
            $display("FAIL async_reset actual clk_out=%b tick=%b required all zero", clk_out, tick_dut);
        end
        ch_en = '1;
        run(2);
        Rst_n = 1'b1;
        run(20);

        @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
